axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 responder backing the core's 64-bit master port with a single-ported word RAM (simulation/FPGA memory model).
//  Accepts one read burst and one write burst concurrently on independent FSMs; supports FIXED/INCR/WRAP bursts and byte strobes.
//  Sits in the difftest top, wired straight to the MAXI_* bus of the core wrapper.
// PARAMETERS
//  ID_WIDTH       4            AXI id width (awid/bid/arid/rid)
//  ADDR_WIDTH     32           AXI address width
//  MEM_WORDS_LOG2 16           log2 of RAM depth in 64-bit words (default 512 KiB)
//  BASE_ADDR      32'h80000000 first byte address decoded; window = BASE_ADDR .. BASE_ADDR + 8*2^MEM_WORDS_LOG2 - 1
// PORTS
//  clock          in   1   single clock, all logic on rising edge
//  reset          in   1   asynchronous, active-low reset (0 = in reset)
//  SAXI_aw{id,addr,len,size,burst} in ID/ADDR/8/3/2  write address; SAXI_awvalid in 1; SAXI_awready out 1
//  SAXI_wdata in 64; SAXI_wstrb in 8; SAXI_wlast in 1; SAXI_wvalid in 1; SAXI_wready out 1
//  SAXI_bid out ID; SAXI_bresp out 2; SAXI_bvalid out 1; SAXI_bready in 1
//  SAXI_ar{id,addr,len,size,burst} in ID/ADDR/8/3/2  read address; SAXI_arvalid in 1; SAXI_arready out 1
//  SAXI_rid out ID; SAXI_rdata out 64; SAXI_rresp out 2; SAXI_rlast out 1; SAXI_rvalid out 1; SAXI_rready in 1
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0; FSMs -> IDLE; beat counters 0. RAM contents are NOT cleared. Reset mid-burst
//   aborts the burst silently (no rlast/bresp issued); beats already written stay written.
//  Readies are registered: awready/arready rise the first cycle after reset release.
//  Read FSM: R_IDLE (arready=1) --arvalid--> R_DATA (arready=0, latch id/addr/len/size/burst, beat=0).
//   First rvalid in cycle T+1 after the AR handshake at T; RAM read registered; one beat per cycle while rready=1.
//   While rvalid & !rready: rdata/rid/rresp/rlast held stable. rlast=1 iff beat==len. Handshake on last beat -> R_IDLE.
//  Write FSM: W_IDLE (awready=1) --awvalid--> W_DATA (wready=1) --beat==len accepted--> W_RESP (bvalid=1) --bready--> W_IDLE.
//   Each accepted W beat writes byte lanes where wstrb[i]=1; lanes with wstrb[i]=0 unchanged. bvalid no earlier than cycle after last W.
//   AW and W ordering: W beats are not accepted (wready=0) until the AW handshake has happened.
//  Address sequencing per beat: FIXED(0) addr constant; INCR(1) addr += 1<<size; WRAP(2) increments within
//   boundary = (len+1)<<size aligned down; burst=3 treated as INCR with resp SLVERR. Word index = addr[MEM_WORDS_LOG2+2:3].
//  Responses: OKAY 2'b00. SLVERR 2'b10 if size>3, burst==3, WRAP with len not in {1,3,7,15}, or wlast != (beat==len).
//   DECERR 2'b11 if any beat's address is outside the window: that beat's write suppressed / rdata=0.
//   bresp = worst (highest) code over all beats; rresp per beat. Beat count always follows len, never wlast.
//  Simultaneous read & write to the same word in one cycle: read returns old data (read-before-write).
//  len=0: single beat, rlast=1 on it. len=255: 256 beats, 8-bit beat counter must not overflow before compare.
//  Address arithmetic done in ADDR_WIDTH bits; INCR past 2^ADDR_WIDTH wraps modulo and decodes as DECERR.
// CONFIGURATION
//  AXI_SLV_RAND_STALL_EN defined: 16-bit LFSR (seed 16'hACE1, x^16+x^14+x^13+x^11) advanced every cycle; when
//   lfsr[0]=1 awready, arready and wready are forced 0 and a pending rvalid beat is delayed one cycle (once asserted,
//   rvalid never drops before handshake). Protocol results identical, only timing differs.
//  Undefined: no stalls; timing exactly as above (full-throughput bursts, 1-cycle read latency).
// TESTING
//  1 Write INCR len=3 size=3 addr=0x80000000 data 0x11..,0x22..,0x33..,0x44.., wstrb=FF -> bresp=0 bid=awid;
//    read back same burst -> 4 beats in consecutive cycles, rlast only on beat 3, rresp=0.
//  2 Write wstrb=8'h0F data 64'hAAAA_BBBB_CCCC_DDDD over word 64'h0 -> read 64'h0000_0000_CCCC_DDDD.
//  3 Read WRAP len=3 size=3 addr=0x80000010 -> words at offsets 0x10,0x18,0x00,0x08 in that order.
//  4 Read addr=0x70000000 len=1 -> two beats rdata=0 rresp=2'b11; write there -> bresp=2'b11, RAM unchanged.
//  5 rready low for 3 cycles mid-burst -> rdata/rlast stable, no beat lost or duplicated; concurrent write burst completes.
//  6 Assert reset mid read burst (beat 2 of 8) -> rvalid=0 immediately; after release arready=1 next cycle, prior RAM intact.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder over a 64-bit word RAM with independent read and write burst FSMs.
// Define AXI_SLV_RAND_STALL_EN to add LFSR-driven random back-pressure (results unchanged, timing only).
module axi_sram_slave #(
    parameter int unsigned            ID_WIDTH       = 4,
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter int unsigned            MEM_WORDS_LOG2 = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ID_WIDTH-1:0]   SAXI_awid,
    input  logic [ADDR_WIDTH-1:0] SAXI_awaddr,
    input  logic [7:0]            SAXI_awlen,
    input  logic [2:0]            SAXI_awsize,
    input  logic [1:0]            SAXI_awburst,
    input  logic                  SAXI_awvalid,
    output logic                  SAXI_awready,

    input  logic [63:0]           SAXI_wdata,
    input  logic [7:0]            SAXI_wstrb,
    input  logic                  SAXI_wlast,
    input  logic                  SAXI_wvalid,
    output logic                  SAXI_wready,

    output logic [ID_WIDTH-1:0]   SAXI_bid,
    output logic [1:0]            SAXI_bresp,
    output logic                  SAXI_bvalid,
    input  logic                  SAXI_bready,

    input  logic [ID_WIDTH-1:0]   SAXI_arid,
    input  logic [ADDR_WIDTH-1:0] SAXI_araddr,
    input  logic [7:0]            SAXI_arlen,
    input  logic [2:0]            SAXI_arsize,
    input  logic [1:0]            SAXI_arburst,
    input  logic                  SAXI_arvalid,
    output logic                  SAXI_arready,

    output logic [ID_WIDTH-1:0]   SAXI_rid,
    output logic [63:0]           SAXI_rdata,
    output logic [1:0]            SAXI_rresp,
    output logic                  SAXI_rlast,
    output logic                  SAXI_rvalid,
    input  logic                  SAXI_rready
);

    localparam int unsigned WIN_SHIFT = MEM_WORDS_LOG2 + 3;

    typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [63:0] r_mem [0:(1<<MEM_WORDS_LOG2)-1];

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> WIN_SHIFT) == '0);
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                             input logic [1:0] burst, input logic [7:0] len);
        if (!in_window(a))
            return 2'b11;
        if ((size > 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len)))
            return 2'b10;
        return 2'b00;
    endfunction

    // Malformed WRAP lengths and the reserved burst code both fall back to INCR stepping.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                                        input logic [1:0] burst, input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] sum;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        sum  = a + step;
        if (burst == 2'b00)
            return a;
        else if ((burst == 2'b10) && wrap_len_ok(len))
            return (a & ~mask) | (sum & mask);
        else
            return sum;
    endfunction

    logic w_stall;
`ifdef AXI_SLV_RAND_STALL_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // ---------------- read channel ----------------
    rstate_t               r_rstate;
    logic                  r_arready;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [7:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rbeat;
    logic [63:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic                  r_rvalid;

    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_rd_load;
    logic [ADDR_WIDTH-1:0]     w_rd_addr;
    logic [7:0]                w_rd_beat;
    logic [7:0]                w_rd_len;
    logic [2:0]                w_rd_size;
    logic [1:0]                w_rd_burst;
    logic [MEM_WORDS_LOG2-1:0] w_rd_idx;

    // Selects which beat's address feeds the registered RAM read this cycle.
    always_comb begin
        w_ar_hs    = (r_rstate == R_IDLE) && SAXI_arvalid && SAXI_arready;
        w_r_hs     = r_rvalid && SAXI_rready;
        w_rd_addr  = r_raddr;
        w_rd_beat  = r_rbeat;
        w_rd_len   = r_arlen;
        w_rd_size  = r_arsize;
        w_rd_burst = r_arburst;
        w_rd_load  = 1'b0;
        if (r_rstate == R_IDLE) begin
            w_rd_addr  = SAXI_araddr;
            w_rd_beat  = '0;
            w_rd_len   = SAXI_arlen;
            w_rd_size  = SAXI_arsize;
            w_rd_burst = SAXI_arburst;
            w_rd_load  = w_ar_hs && !w_stall;
        end else if (w_r_hs) begin
            w_rd_addr = next_addr(r_raddr, r_arsize, r_arburst, r_arlen);
            w_rd_beat = r_rbeat + 8'd1;
            w_rd_load = !r_rlast && !w_stall;
        end else begin
            w_rd_load = !r_rvalid && !w_stall;
        end
        w_rd_idx = w_rd_addr[MEM_WORDS_LOG2+2:3];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rid     <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_raddr   <= '0;
            r_rbeat   <= '0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rid     <= SAXI_arid;
                        r_arlen   <= SAXI_arlen;
                        r_arsize  <= SAXI_arsize;
                        r_arburst <= SAXI_arburst;
                        r_raddr   <= SAXI_araddr;
                        r_rbeat   <= '0;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs && r_rlast) begin
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rlast   <= 1'b0;
                    end else if (w_r_hs) begin
                        r_raddr <= w_rd_addr;
                        r_rbeat <= w_rd_beat;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase

            if (w_rd_load) begin
                r_rvalid <= 1'b1;
                r_rdata  <= in_window(w_rd_addr) ? r_mem[w_rd_idx] : '0;
                r_rresp  <= beat_resp(w_rd_addr, w_rd_size, w_rd_burst, w_rd_len);
                r_rlast  <= (w_rd_beat == w_rd_len);
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- write channel ----------------
    wstate_t               r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [7:0]            r_awlen;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wbeat;
    logic [1:0]            r_bacc;
    logic [1:0]            r_bresp;
    logic                  r_bvalid;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_wr_last;
    logic [1:0]                w_wr_resp;
    logic [1:0]                w_wr_worst;
    logic                      w_mem_we;
    logic [MEM_WORDS_LOG2-1:0] w_wr_idx;

    always_comb begin
        w_aw_hs   = (r_wstate == W_IDLE) && SAXI_awvalid && SAXI_awready;
        w_w_hs    = (r_wstate == W_DATA) && SAXI_wvalid && SAXI_wready;
        w_wr_last = (r_wbeat == r_awlen);
        w_wr_resp = beat_resp(r_waddr, r_awsize, r_awburst, r_awlen);
        if ((SAXI_wlast != w_wr_last) && (w_wr_resp < 2'b10))
            w_wr_resp = 2'b10;
        w_wr_worst = (w_wr_resp > r_bacc) ? w_wr_resp : r_bacc;
        w_mem_we   = w_w_hs && in_window(r_waddr);
        w_wr_idx   = r_waddr[MEM_WORDS_LOG2+2:3];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bid     <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_waddr   <= '0;
            r_wbeat   <= '0;
            r_bacc    <= '0;
            r_bresp   <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_DATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= SAXI_awid;
                        r_awlen   <= SAXI_awlen;
                        r_awsize  <= SAXI_awsize;
                        r_awburst <= SAXI_awburst;
                        r_waddr   <= SAXI_awaddr;
                        r_wbeat   <= '0;
                        r_bacc    <= '0;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        if (w_wr_last) begin
                            r_wstate <= W_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_wr_worst;
                        end else begin
                            r_waddr <= next_addr(r_waddr, r_awsize, r_awburst, r_awlen);
                            r_wbeat <= r_wbeat + 8'd1;
                            r_bacc  <= w_wr_worst;
                        end
                    end
                end
                W_RESP: begin
                    if (SAXI_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (SAXI_wstrb[i])
                    r_mem[w_wr_idx][i*8 +: 8] <= SAXI_wdata[i*8 +: 8];
            end
        end
    end

    assign SAXI_awready = r_awready & ~w_stall;
    assign SAXI_wready  = r_wready & ~w_stall;
    assign SAXI_arready = r_arready & ~w_stall;
    assign SAXI_bid     = r_bid;
    assign SAXI_bresp   = r_bresp;
    assign SAXI_bvalid  = r_bvalid;
    assign SAXI_rid     = r_rid;
    assign SAXI_rdata   = r_rdata;
    assign SAXI_rresp   = r_rresp;
    assign SAXI_rlast   = r_rlast;
    assign SAXI_rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed AXI burst vectors against axi_sram_slave with hand-computed expectations.
module tb_axi_sram_slave;

    logic        clock;
    logic        reset;
    logic [3:0]  SAXI_awid;
    logic [31:0] SAXI_awaddr;
    logic [7:0]  SAXI_awlen;
    logic [2:0]  SAXI_awsize;
    logic [1:0]  SAXI_awburst;
    logic        SAXI_awvalid;
    logic        SAXI_awready;
    logic [63:0] SAXI_wdata;
    logic [7:0]  SAXI_wstrb;
    logic        SAXI_wlast;
    logic        SAXI_wvalid;
    logic        SAXI_wready;
    logic [3:0]  SAXI_bid;
    logic [1:0]  SAXI_bresp;
    logic        SAXI_bvalid;
    logic        SAXI_bready;
    logic [3:0]  SAXI_arid;
    logic [31:0] SAXI_araddr;
    logic [7:0]  SAXI_arlen;
    logic [2:0]  SAXI_arsize;
    logic [1:0]  SAXI_arburst;
    logic        SAXI_arvalid;
    logic        SAXI_arready;
    logic [3:0]  SAXI_rid;
    logic [63:0] SAXI_rdata;
    logic [1:0]  SAXI_rresp;
    logic        SAXI_rlast;
    logic        SAXI_rvalid;
    logic        SAXI_rready;

    axi_sram_slave dut (
        .clock(clock), .reset(reset),
        .SAXI_awid(SAXI_awid), .SAXI_awaddr(SAXI_awaddr), .SAXI_awlen(SAXI_awlen),
        .SAXI_awsize(SAXI_awsize), .SAXI_awburst(SAXI_awburst), .SAXI_awvalid(SAXI_awvalid),
        .SAXI_awready(SAXI_awready),
        .SAXI_wdata(SAXI_wdata), .SAXI_wstrb(SAXI_wstrb), .SAXI_wlast(SAXI_wlast),
        .SAXI_wvalid(SAXI_wvalid), .SAXI_wready(SAXI_wready),
        .SAXI_bid(SAXI_bid), .SAXI_bresp(SAXI_bresp), .SAXI_bvalid(SAXI_bvalid), .SAXI_bready(SAXI_bready),
        .SAXI_arid(SAXI_arid), .SAXI_araddr(SAXI_araddr), .SAXI_arlen(SAXI_arlen),
        .SAXI_arsize(SAXI_arsize), .SAXI_arburst(SAXI_arburst), .SAXI_arvalid(SAXI_arvalid),
        .SAXI_arready(SAXI_arready),
        .SAXI_rid(SAXI_rid), .SAXI_rdata(SAXI_rdata), .SAXI_rresp(SAXI_rresp), .SAXI_rlast(SAXI_rlast),
        .SAXI_rvalid(SAXI_rvalid), .SAXI_rready(SAXI_rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] wb_data [0:255];
    logic [1:0]  wb_bresp;
    logic [3:0]  wb_bid;
    logic [63:0] rb_data [0:255];
    logic [1:0]  rb_resp [0:255];
    logic        rb_last [0:255];
    logic [3:0]  rb_id   [0:255];
    int          rb_n;
    int          rb_gaps;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_0000_0000 + 64'(i);
    endfunction

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                            input int wlast_all);
        int t;
        @(negedge clock);
        SAXI_awid = id; SAXI_awaddr = addr; SAXI_awlen = len;
        SAXI_awsize = size; SAXI_awburst = burst; SAXI_awvalid = 1'b1;
        t = 0;
        while (!SAXI_awready && t < 200) begin @(negedge clock); t++; end
        if (t >= 200) check("aw_timeout", 1, 0);
        @(negedge clock);
        SAXI_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            SAXI_wvalid = 1'b1;
            SAXI_wdata  = wb_data[i];
            SAXI_wstrb  = strb;
            SAXI_wlast  = (wlast_all != 0) || (i == int'(len));
            t = 0;
            while (!SAXI_wready && t < 200) begin @(negedge clock); t++; end
            if (t >= 200) check("w_timeout", 1, 0);
            @(negedge clock);
        end
        SAXI_wvalid = 1'b0;
        SAXI_wlast  = 1'b0;
        t = 0;
        while (!SAXI_bvalid && t < 200) begin @(negedge clock); t++; end
        if (t >= 200) check("b_timeout", 1, 0);
        wb_bresp = SAXI_bresp;
        wb_bid   = SAXI_bid;
        @(negedge clock);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall_at);
        int t;
        logic [63:0] hold_d;
        logic        hold_l;
        @(negedge clock);
        SAXI_arid = id; SAXI_araddr = addr; SAXI_arlen = len;
        SAXI_arsize = size; SAXI_arburst = burst; SAXI_arvalid = 1'b1;
        t = 0;
        while (!SAXI_arready && t < 200) begin @(negedge clock); t++; end
        if (t >= 200) check("ar_timeout", 1, 0);
        @(negedge clock);
        SAXI_arvalid = 1'b0;
        rb_n = 0; rb_gaps = 0; t = 0;
        while (rb_n <= int'(len) && t < 600) begin
            if (SAXI_rvalid) begin
                if (rb_n == stall_at) begin
                    hold_d = SAXI_rdata;
                    hold_l = SAXI_rlast;
                    SAXI_rready = 1'b0;
                    repeat (3) begin
                        @(negedge clock);
                        check("hold_rvalid", SAXI_rvalid, 1);
                        check("hold_rdata", SAXI_rdata, hold_d);
                        check("hold_rlast", SAXI_rlast, hold_l);
                    end
                    SAXI_rready = 1'b1;
                end
                rb_data[rb_n] = SAXI_rdata;
                rb_resp[rb_n] = SAXI_rresp;
                rb_last[rb_n] = SAXI_rlast;
                rb_id[rb_n]   = SAXI_rid;
                rb_n++;
            end else begin
                rb_gaps++;
            end
            @(negedge clock);
            t++;
        end
        if (t >= 600) check("r_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        SAXI_awid = '0; SAXI_awaddr = '0; SAXI_awlen = '0; SAXI_awsize = '0; SAXI_awburst = '0;
        SAXI_awvalid = 1'b0; SAXI_wdata = '0; SAXI_wstrb = '0; SAXI_wlast = 1'b0; SAXI_wvalid = 1'b0;
        SAXI_bready = 1'b1;
        SAXI_arid = '0; SAXI_araddr = '0; SAXI_arlen = '0; SAXI_arsize = '0; SAXI_arburst = '0;
        SAXI_arvalid = 1'b0; SAXI_rready = 1'b1;

        repeat (3) @(negedge clock);
        check("rst_awready", SAXI_awready, 0);
        check("rst_arready", SAXI_arready, 0);
        check("rst_wready", SAXI_wready, 0);
        check("rst_bvalid", SAXI_bvalid, 0);
        check("rst_rvalid", SAXI_rvalid, 0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_awready", SAXI_awready, 1);
        check("rel_arready", SAXI_arready, 1);

        // INCR write then read back, full throughput
        wb_data[0] = 64'h1111_1111_1111_1111; wb_data[1] = 64'h2222_2222_2222_2222;
        wb_data[2] = 64'h3333_3333_3333_3333; wb_data[3] = 64'h4444_4444_4444_4444;
        wr_burst(4'd5, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 8'hFF, 0);
        check("t1_bresp", wb_bresp, 0);
        check("t1_bid", wb_bid, 5);
        rd_burst(4'd9, 32'h8000_0000, 8'd3, 3'd3, 2'b01, -1);
        check("t1_nbeats", rb_n, 4);
        check("t1_gaps", rb_gaps, 0);
        for (int i = 0; i < 4; i++) begin
            check("t1_rdata", rb_data[i], wb_data[i]);
            check("t1_rresp", rb_resp[i], 0);
            check("t1_rlast", rb_last[i], (i == 3));
            check("t1_rid", rb_id[i], 9);
        end

        // byte strobes
        wb_data[0] = 64'h0;
        wr_burst(4'd1, 32'h8000_0020, 8'd0, 3'd3, 2'b01, 8'hFF, 0);
        wb_data[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        wr_burst(4'd1, 32'h8000_0020, 8'd0, 3'd3, 2'b01, 8'h0F, 0);
        check("t2_bresp", wb_bresp, 0);
        rd_burst(4'd1, 32'h8000_0020, 8'd0, 3'd3, 2'b01, -1);
        check("t2_rdata", rb_data[0], 64'h0000_0000_CCCC_DDDD);
        check("t2_rlast", rb_last[0], 1);

        // WRAP read
        rd_burst(4'd2, 32'h8000_0010, 8'd3, 3'd3, 2'b10, -1);
        check("t3_b0", rb_data[0], 64'h3333_3333_3333_3333);
        check("t3_b1", rb_data[1], 64'h4444_4444_4444_4444);
        check("t3_b2", rb_data[2], 64'h1111_1111_1111_1111);
        check("t3_b3", rb_data[3], 64'h2222_2222_2222_2222);
        check("t3_rresp", rb_resp[3], 0);

        // outside the window
        rd_burst(4'd3, 32'h7000_0000, 8'd1, 3'd3, 2'b01, -1);
        check("t4_rdata0", rb_data[0], 0);
        check("t4_rdata1", rb_data[1], 0);
        check("t4_rresp0", rb_resp[0], 2'b11);
        check("t4_rresp1", rb_resp[1], 2'b11);
        wb_data[0] = 64'hDEAD_BEEF_DEAD_BEEF; wb_data[1] = 64'hBAD0_BAD0_BAD0_BAD0;
        wr_burst(4'd3, 32'h7000_0000, 8'd1, 3'd3, 2'b01, 8'hFF, 0);
        check("t4_bresp", wb_bresp, 2'b11);
        rd_burst(4'd3, 32'h8000_0000, 8'd0, 3'd3, 2'b01, -1);
        check("t4_ram_intact", rb_data[0], 64'h1111_1111_1111_1111);

        // reserved burst, FIXED, bad WRAP length, wlast mismatch
        rd_burst(4'd4, 32'h8000_0008, 8'd0, 3'd3, 2'b11, -1);
        check("rsv_rdata", rb_data[0], 64'h2222_2222_2222_2222);
        check("rsv_rresp", rb_resp[0], 2'b10);
        rd_burst(4'd4, 32'h8000_0018, 8'd2, 3'd3, 2'b00, -1);
        for (int i = 0; i < 3; i++) begin
            check("fix_rdata", rb_data[i], 64'h4444_4444_4444_4444);
            check("fix_rlast", rb_last[i], (i == 2));
        end
        check("fix_rresp", rb_resp[0], 0);
        rd_burst(4'd4, 32'h8000_0000, 8'd2, 3'd3, 2'b10, -1);
        check("wraplen_rresp", rb_resp[0], 2'b10);
        wb_data[0] = 64'h7; wb_data[1] = 64'h8;
        wr_burst(4'd6, 32'h8000_0100, 8'd1, 3'd3, 2'b01, 8'hFF, 1);
        check("wlast_bresp", wb_bresp, 2'b10);
        check("wlast_bid", wb_bid, 6);

        // 256-beat burst
        for (int i = 0; i < 256; i++) wb_data[i] = pat(i);
        wr_burst(4'd7, 32'h8000_1000, 8'd255, 3'd3, 2'b01, 8'hFF, 0);
        check("l256_bresp", wb_bresp, 0);
        rd_burst(4'd7, 32'h8000_1000, 8'd255, 3'd3, 2'b01, -1);
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < 256; i++)
                if (rb_data[i] !== pat(i) || rb_last[i] !== (i == 255)) errs++;
            check("l256_nbeats", rb_n, 256);
            check("l256_errs", errs, 0);
            check("l256_b255", rb_data[255], pat(255));
            check("l256_last", rb_last[255], 1);
        end

        // rready back-pressure with a concurrent write burst
        for (int i = 0; i < 4; i++) wb_data[i] = 64'h5555_0000_0000_0000 + 64'(i);
        fork
            rd_burst(4'd8, 32'h8000_1000, 8'd7, 3'd3, 2'b01, 3);
            wr_burst(4'd8, 32'h8000_2000, 8'd3, 3'd3, 2'b01, 8'hFF, 0);
        join
        check("t5_nbeats", rb_n, 8);
        for (int i = 0; i < 8; i++) check("t5_rdata", rb_data[i], pat(i));
        check("t5_rlast", rb_last[7], 1);
        check("t5_bresp", wb_bresp, 0);
        rd_burst(4'd8, 32'h8000_2000, 8'd3, 3'd3, 2'b01, -1);
        for (int i = 0; i < 4; i++) check("t5_wback", rb_data[i], 64'h5555_0000_0000_0000 + 64'(i));

        // reset in the middle of a read burst
        @(negedge clock);
        SAXI_arid = 4'd2; SAXI_araddr = 32'h8000_1000; SAXI_arlen = 8'd7;
        SAXI_arsize = 3'd3; SAXI_arburst = 2'b01; SAXI_arvalid = 1'b1;
        begin
            int t;
            t = 0;
            while (!SAXI_arready && t < 200) begin @(negedge clock); t++; end
            if (t >= 200) check("t6_ar_timeout", 1, 0);
        end
        @(negedge clock);
        SAXI_arvalid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t6_beat2", SAXI_rdata, pat(2));
        #2 reset = 1'b0;
        #1;
        check("t6_rvalid", SAXI_rvalid, 0);
        check("t6_arready", SAXI_arready, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_arready_rel", SAXI_arready, 1);
        check("t6_rvalid_rel", SAXI_rvalid, 0);
        rd_burst(4'd0, 32'h8000_0000, 8'd0, 3'd3, 2'b01, -1);
        check("t6_ram0", rb_data[0], 64'h1111_1111_1111_1111);
        rd_burst(4'd0, 32'h8000_1010, 8'd0, 3'd3, 2'b01, -1);
        check("t6_ram1", rb_data[0], pat(2));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
